procyon_ifq: RTL and testbench

- Instruction fetch miss queue: accepts I-cache line misses from fetch and issues line reads to the CCU arbiter through a request-channel port.
- The port is identical in shape to the VQ/MHQ ports (en/we/len/addr, grant, done/data).
- Returns the filled line to the I-cache.
- Sits upstream of the CCU arbiter as an additional requestor, alongside the VQ and MHQ.

---
 rtl/procyon_ifq.sv | 162 ++++++++++++++++
 tb/tb_procyon_ifq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procyon_ifq.sv
// Instruction fetch miss queue: coalesces I-cache line misses, issues one line read
// at a time on the CCU request port and returns each filled line to the I-cache.
//
// state | meaning
// IDLE  | no request outstanding; starts one when the head entry is valid
// REQ   | read request presented to the CCU arbiter, waiting for grant (or early done)
// WAIT  | request granted, waiting for read completion
// FILL  | one-cycle fill pulse to the I-cache; head entry retired

`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 4
`endif

module procyon_ifq #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_IFQ_DEPTH    = 2,
    parameter int OPTN_IC_LINE_SIZE = 32,
    parameter int IC_LINE_WIDTH     = OPTN_IC_LINE_SIZE * 8
) (
    input  logic                            clk,
    input  logic                            n_rst,

    input  logic                            i_ifq_lookup_valid,
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_ifq_lookup_addr,
    output logic                            o_ifq_lookup_retry,
    input  logic                            i_ifq_flush,

    output logic                            o_ifq_fill_en,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_ifq_fill_addr,
    output logic [IC_LINE_WIDTH-1:0]        o_ifq_fill_data,

    input  logic                            i_ccu_grant,
    input  logic                            i_ccu_done,
    input  logic [IC_LINE_WIDTH-1:0]        i_ccu_data,
    output logic                            o_ccu_en,
    output logic                            o_ccu_we,
    output logic [`PCYN_CCU_LEN_WIDTH-1:0]  o_ccu_len,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_ccu_addr
);

    localparam int IDX_WIDTH = $clog2(OPTN_IFQ_DEPTH);
    localparam logic [OPTN_ADDR_WIDTH-1:0] OFFSET_MASK = OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1);
    localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH + 1)'(OPTN_IFQ_DEPTH);
    localparam logic [IDX_WIDTH:0] ONE_COUNT  = (IDX_WIDTH + 1)'(1);
    localparam logic [IDX_WIDTH-1:0] PTR_ONE  = IDX_WIDTH'(1);
    // Length code is log2 of the transfer size in bytes.
    localparam logic [`PCYN_CCU_LEN_WIDTH-1:0] CCU_LEN = `PCYN_CCU_LEN_WIDTH'($clog2(OPTN_IC_LINE_SIZE));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [OPTN_IFQ_DEPTH-1:0]                       entry_valid;
    logic [OPTN_IFQ_DEPTH-1:0][OPTN_ADDR_WIDTH-1:0]  entry_addr;
    logic [IDX_WIDTH-1:0]                            head;
    logic [IDX_WIDTH-1:0]                            tail;
    logic [IDX_WIDTH:0]                              count;

    logic [OPTN_ADDR_WIDTH-1:0] lookup_line;
    logic                       lookup_hit;
    logic                       queue_full;
    logic                       alloc;
    logic                       dequeue;
    logic                       busy;
    logic                       ccu_active;
    logic                       fill_capture;

    always_comb begin
        lookup_line = i_ifq_lookup_addr & ~OFFSET_MASK;
        lookup_hit  = 1'b0;
        for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == lookup_line)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle dequeue does not free a slot.
    assign queue_full         = (count == FULL_COUNT);
    assign alloc              = i_ifq_lookup_valid && !i_ifq_flush && !lookup_hit && !queue_full;
    assign o_ifq_lookup_retry = i_ifq_lookup_valid && !i_ifq_flush && !lookup_hit && queue_full;

    assign busy         = (state != ST_IDLE);
    assign ccu_active   = (state == ST_REQ) || (state == ST_WAIT);
    assign dequeue      = (state == ST_FILL);
    assign fill_capture = ccu_active && i_ccu_done;

    assign o_ccu_en      = ccu_active;
    assign o_ccu_we      = 1'b0;
    assign o_ccu_len     = CCU_LEN;
    assign o_ccu_addr    = ccu_active ? entry_addr[head] : '0;
    assign o_ifq_fill_en = (state == ST_FILL);

    always_comb begin
        state_next = state;
        unique case (state)
            // An allocation into an empty queue lands at head, so the request can start at once.
            ST_IDLE: if (!i_ifq_flush && (entry_valid[head] || alloc)) state_next = ST_REQ;
            ST_REQ: begin
                if (i_ccu_done) state_next = ST_FILL;
                else if (i_ccu_grant) state_next = ST_WAIT;
            end
            ST_WAIT: if (i_ccu_done) state_next = ST_FILL;
            ST_FILL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            entry_valid <= '0;
            entry_addr  <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (i_ifq_flush) begin
                for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
                    if (!(busy && (IDX_WIDTH'(i) == head))) entry_valid[i] <= 1'b0;
                end
            end
            if (dequeue) begin
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_ONE;
            end
            if (alloc) begin
                entry_valid[tail] <= 1'b1;
                entry_addr[tail]  <= lookup_line;
            end

            if (i_ifq_flush) begin
                tail  <= busy ? head + PTR_ONE : head;
                count <= (busy && !dequeue) ? ONE_COUNT : '0;
            end else begin
                if (alloc) tail <= tail + PTR_ONE;
                count <= count + (IDX_WIDTH + 1)'(alloc) - (IDX_WIDTH + 1)'(dequeue);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_ifq_fill_addr <= '0;
            o_ifq_fill_data <= '0;
        end else if (fill_capture) begin
            o_ifq_fill_addr <= entry_addr[head];
            o_ifq_fill_data <= i_ccu_data;
        end
    end

endmodule

// File: tb/tb_procyon_ifq.sv
// Directed bench for procyon_ifq: a queue-level model is checked against the DUT every
// cycle, and each scenario also pins a few literal cycle-exact expectations.

module tb_procyon_ifq;

    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int LW    = 256;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          lookup_valid;
    logic [AW-1:0] lookup_addr;
    logic          lookup_retry;
    logic          flush;
    logic          fill_en;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic          ccu_grant;
    logic          ccu_done;
    logic [LW-1:0] ccu_data;
    logic          ccu_en;
    logic          ccu_we;
    logic [3:0]    ccu_len;
    logic [AW-1:0] ccu_addr;

    int compared   = 0;
    int mismatched = 0;

    procyon_ifq #(
        .OPTN_ADDR_WIDTH   (AW),
        .OPTN_IFQ_DEPTH    (DEPTH),
        .OPTN_IC_LINE_SIZE (32)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .i_ifq_lookup_valid (lookup_valid),
        .i_ifq_lookup_addr  (lookup_addr),
        .o_ifq_lookup_retry (lookup_retry),
        .i_ifq_flush        (flush),
        .o_ifq_fill_en      (fill_en),
        .o_ifq_fill_addr    (fill_addr),
        .o_ifq_fill_data    (fill_data),
        .i_ccu_grant        (ccu_grant),
        .i_ccu_done         (ccu_done),
        .i_ccu_data         (ccu_data),
        .o_ccu_en           (ccu_en),
        .o_ccu_we           (ccu_we),
        .o_ccu_len          (ccu_len),
        .o_ccu_addr         (ccu_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds line addresses oldest first; the front is the in-flight line.
    logic [AW-1:0] mq[$];
    logic          m_out;
    logic          m_fill;
    logic [AW-1:0] m_fa;
    logic [LW-1:0] m_fd;
    logic [AW-1:0] fill_log[$];
    int            req_count = 0;
    logic          prev_en = 1'b0;

    always @(negedge clk) begin
        logic [AW-1:0] line;
        logic hit, full, exp_retry, accept, old_busy;
        int old_size;
        if (!n_rst) begin
            check("rst_ccu_en", ccu_en, 0);
            check("rst_fill_en", fill_en, 0);
            check("rst_fill_addr", fill_addr, 0);
            check("rst_fill_data", fill_data, 0);
            check("rst_ccu_addr", ccu_addr, 0);
            check("rst_retry", lookup_retry, 0);
            mq.delete();
            m_out = 0; m_fill = 0; m_fa = '0; m_fd = '0; prev_en = 0;
        end else begin
            line = lookup_addr & ~32'h1F;
            hit = 0;
            foreach (mq[i]) if (mq[i] == line) hit = 1;
            full      = (mq.size() == DEPTH);
            exp_retry = lookup_valid && !flush && !hit && full;
            accept    = lookup_valid && !flush && !hit && !full;

            check("m_ccu_en", ccu_en, m_out);
            check("m_ccu_addr", ccu_addr, (m_out && mq.size() > 0) ? mq[0] : 32'h0);
            check("m_ccu_we", ccu_we, 0);
            check("m_ccu_len", ccu_len, 5);
            check("m_fill_en", fill_en, m_fill);
            check("m_fill_addr", fill_addr, m_fa);
            check("m_fill_data", fill_data, m_fd);
            check("m_retry", lookup_retry, exp_retry);

            if (fill_en) fill_log.push_back(fill_addr);
            if (ccu_en && !prev_en) req_count++;
            prev_en = ccu_en;

            old_busy = m_out || m_fill;
            old_size = mq.size();
            if (flush) begin
                if (old_busy) begin
                    while (mq.size() > 1) void'(mq.pop_back());
                end else begin
                    mq.delete();
                end
            end
            if (m_fill) begin
                void'(mq.pop_front());
                m_fill = 0;
            end
            if (m_out && ccu_done) begin
                m_out = 0; m_fill = 1; m_fa = mq[0]; m_fd = ccu_data;
            end else if (!old_busy && !flush && (old_size > 0 || accept)) begin
                m_out = 1;
            end
            if (accept) mq.push_back(line);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lookup_valid = 0; flush = 0; ccu_grant = 0; ccu_done = 0;
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        lookup_valid = 1; lookup_addr = a;
    endtask

    task automatic serve(input logic [AW-1:0] a, input logic [LW-1:0] d);
        int n = 0;
        while (!ccu_en && n < 20) begin cyc(); n++; end
        #1;
        check("serve_req_seen", ccu_en, 1);
        check("serve_req_addr", ccu_addr, a);
        ccu_grant = 1; cyc();
        cyc();
        ccu_done = 1; ccu_data = d; cyc();
        #1;
        check("serve_fill_en", fill_en, 1);
        check("serve_fill_addr", fill_addr, a);
        check("serve_fill_data", fill_data, d);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0;
        n_rst = 0; lookup_valid = 0; lookup_addr = '0; flush = 0;
        ccu_grant = 0; ccu_done = 0; ccu_data = '0;
        repeat (3) cyc();
        n_rst = 1;

        // Single miss with cycle-exact latency.
        lookup(32'h1004); #1;
        check("single_retry", lookup_retry, 0);
        cyc();                                     // cycle 1
        #1;
        check("single_en_c1", ccu_en, 1);
        check("single_addr_c1", ccu_addr, 32'h1000);
        cyc(); ccu_grant = 1;                      // cycle 2
        cyc(); cyc();                              // cycle 4
        cyc(); ccu_done = 1; ccu_data = {8{32'hD00D_0001}}; #1;  // cycle 5
        check("single_fill_c5", fill_en, 0);
        check("single_en_c5", ccu_en, 1);
        cyc(); #1;                                 // cycle 6
        check("single_fill_c6", fill_en, 1);
        check("single_fill_addr", fill_addr, 32'h1000);
        check("single_fill_data", fill_data, {8{32'hD00D_0001}});
        cyc(); #1;                                 // cycle 7
        check("single_fill_c7", fill_en, 0);
        check("single_we", ccu_we, 0);
        cyc();

        // Coalesce a second miss to the same line while in WAIT.
        f0 = fill_log.size(); r0 = req_count;
        lookup(32'h2000); cyc();
        ccu_grant = 1; cyc();
        lookup(32'h201C); #1;
        check("coal_retry", lookup_retry, 0);
        cyc();
        ccu_done = 1; ccu_data = {8{32'hC0A1_0002}}; cyc(); #1;
        check("coal_fill_addr", fill_addr, 32'h2000);
        repeat (4) cyc();
        check("coal_req_count", req_count - r0, 1);
        check("coal_fill_count", fill_log.size() - f0, 1);

        // Full queue, retry while head dequeues, then wrap into slot 0.
        f0 = fill_log.size();
        lookup(32'h3000); cyc();
        lookup(32'h4000); #1;
        check("full_accept_4000", lookup_retry, 0);
        cyc();
        lookup(32'h5000); ccu_grant = 1; #1;
        check("full_retry_a", lookup_retry, 1);
        cyc();
        lookup(32'h5000); ccu_done = 1; ccu_data = {8{32'h3333_3333}}; #1;
        check("full_retry_b", lookup_retry, 1);
        cyc();
        lookup(32'h5000); #1;
        check("full_fill_3000", fill_en, 1);
        check("full_retry_during_fill", lookup_retry, 1);
        cyc();
        lookup(32'h5000); #1;
        check("full_accept_5000", lookup_retry, 0);
        cyc();
        serve(32'h4000, {8{32'h4444_4444}});
        serve(32'h5000, {8{32'h5555_5555}});
        check("order_count", fill_log.size() - f0, 3);
        if (fill_log.size() - f0 == 3) begin
            check("order_0", fill_log[f0], 32'h3000);
            check("order_1", fill_log[f0 + 1], 32'h4000);
            check("order_2", fill_log[f0 + 2], 32'h5000);
        end

        // Flush keeps the in-flight head, drops the queued line.
        r0 = req_count;
        lookup(32'h6000); cyc();
        lookup(32'h7000); ccu_grant = 1; cyc();
        flush = 1; cyc();
        cyc();
        ccu_done = 1; ccu_data = {8{32'h6666_6666}}; cyc(); #1;
        check("flush_fill_en", fill_en, 1);
        check("flush_fill_addr", fill_addr, 32'h6000);
        cyc();
        repeat (3) begin cyc(); #1; check("flush_no_req", ccu_en, 0); end
        check("flush_req_count", req_count - r0, 1);
        lookup(32'h8000); #1; check("flush_acc_8000", lookup_retry, 0); cyc();
        lookup(32'h9000); #1; check("flush_acc_9000", lookup_retry, 0); cyc();
        lookup(32'hA000); #1; check("flush_full_a000", lookup_retry, 1); cyc();
        serve(32'h8000, {8{32'h8888_8888}});
        serve(32'h9000, {8{32'h9999_9999}});

        // Done accepted in REQ without a grant.
        lookup(32'hB000); cyc(); #1;
        check("early_en", ccu_en, 1);
        ccu_done = 1; ccu_data = {8{32'hBBBB_0000}}; cyc(); #1;
        check("early_fill_en", fill_en, 1);
        check("early_fill_addr", fill_addr, 32'hB000);
        check("early_fill_data", fill_data, {8{32'hBBBB_0000}});
        cyc(); #1;
        check("early_idle", ccu_en, 0);
        lookup(32'hC000); cyc(); #1;
        check("early_next_en", ccu_en, 1);
        check("early_next_addr", ccu_addr, 32'hC000);
        serve(32'hC000, {8{32'hCCCC_CCCC}});

        // Asynchronous reset while WAITing.
        lookup(32'hD000); cyc();
        ccu_grant = 1; cyc();
        #2 n_rst = 0;
        #1;
        check("arst_en_now", ccu_en, 0);
        check("arst_addr_now", ccu_addr, 0);
        f0 = fill_log.size();
        cyc(); cyc();
        n_rst = 1;
        repeat (4) begin cyc(); #1; check("arst_no_req", ccu_en, 0); end
        check("arst_no_fill", fill_log.size() - f0, 0);
        lookup(32'hE004); #1;
        check("arst_accept", lookup_retry, 0);
        cyc(); #1;
        check("arst_en", ccu_en, 1);
        check("arst_addr", ccu_addr, 32'hE000);
        serve(32'hE000, {8{32'hEEEE_EEEE}});
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
